// File: rtl/banked_scratchpad_if.sv
// Port bundle for banked_scratchpad: scalar port A, row-wide port B and collision status.
// The master drives accesses; the slave is the scratchpad.
interface banked_scratchpad_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 8
);
  logic                            en_a;
  logic                            we_a;
  logic [ADDR_WIDTH-1:0]           addr_a;
  logic [DATA_WIDTH-1:0]           din_a;
  logic [DATA_WIDTH-1:0]           dout_a;
  logic                            dout_a_valid;
  logic                            en_b;
  logic [NUM_BANKS-1:0]            we_b;
  logic [ADDR_WIDTH-1:0]           addr_b;
  logic [NUM_BANKS*DATA_WIDTH-1:0] din_b;
  logic [NUM_BANKS*DATA_WIDTH-1:0] dout_b;
  logic                            dout_b_valid;
  logic                            collision;
  logic [15:0]                     collision_cnt;

  modport master (
    output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    input  dout_a, dout_a_valid, dout_b, dout_b_valid, collision, collision_cnt
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    output dout_a, dout_a_valid, dout_b, dout_b_valid, collision, collision_cnt
  );
endinterface

// File: rtl/banked_scratchpad.sv
// Dual-port banked scratchpad: scalar port A, row-wide port B, read-first, B wins write collisions.
// Define SPAD_COLLISION_CNT_EN to build the sticky collision flag and saturating collision counter.
module banked_scratchpad #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BANKS    = 8,
  parameter int READ_LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  banked_scratchpad_if.slave bus
);
  localparam int ROW_W    = ADDR_WIDTH - 3;
  localparam int ROWS     = 1 << ROW_W;
  localparam int ROW_BITS = NUM_BANKS * DATA_WIDTH;

  logic [ROW_BITS-1:0] mem [ROWS];

  logic [ROW_W-1:0] row_a;
  logic [ROW_W-1:0] row_b;
  logic [2:0]       bank_a;
  logic             rd_a;
  logic             wr_a;
  logic             rd_b;
  logic             drop_a;
  logic             commit_a;

  assign row_a    = bus.addr_a[ADDR_WIDTH-1:3];
  assign bank_a   = bus.addr_a[2:0];
  assign row_b    = bus.addr_b[ADDR_WIDTH-1:3];
  assign rd_a     = ~rst & bus.en_a & ~bus.we_a;
  assign wr_a     = ~rst & bus.en_a & bus.we_a;
  assign rd_b     = ~rst & bus.en_b & (bus.we_b == '0);
  // A B write landing on the same row and bank as an A write takes the word
  assign drop_a   = wr_a & bus.en_b & bus.we_b[bank_a] & (row_a == row_b);
  assign commit_a = wr_a & ~drop_a;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (commit_a)
        mem[row_a][bank_a*DATA_WIDTH +: DATA_WIDTH] <= bus.din_a;
      if (bus.en_b) begin
        for (int k = 0; k < NUM_BANKS; k++) begin
          if (bus.we_b[k])
            mem[row_b][k*DATA_WIDTH +: DATA_WIDTH] <= bus.din_b[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] va_q, va_d;
  logic [READ_LATENCY-1:0] vb_q, vb_d;
  logic [DATA_WIDTH-1:0]   da_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   da_d [READ_LATENCY];
  logic [ROW_BITS-1:0]     db_q [READ_LATENCY];
  logic [ROW_BITS-1:0]     db_d [READ_LATENCY];

  // Stage data only advances with its valid, so the last stage holds the last read result
  always_comb begin
    va_d    = va_q;
    vb_d    = vb_q;
    da_d    = da_q;
    db_d    = db_q;
    va_d[0] = rd_a;
    vb_d[0] = rd_b;
    if (rd_a) da_d[0] = mem[row_a][bank_a*DATA_WIDTH +: DATA_WIDTH];
    if (rd_b) db_d[0] = mem[row_b];
    for (int i = 1; i < READ_LATENCY; i++) begin
      va_d[i] = va_q[i-1];
      vb_d[i] = vb_q[i-1];
      if (va_q[i-1]) da_d[i] = da_q[i-1];
      if (vb_q[i-1]) db_d[i] = db_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q <= '0;
      vb_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
      da_q <= da_d;
      db_q <= db_d;
    end
  end

  assign bus.dout_a       = da_q[READ_LATENCY-1];
  assign bus.dout_a_valid = va_q[READ_LATENCY-1];
  assign bus.dout_b       = db_q[READ_LATENCY-1];
  assign bus.dout_b_valid = vb_q[READ_LATENCY-1];

`ifdef SPAD_COLLISION_CNT_EN
  logic        collision_q, collision_d;
  logic [15:0] collision_cnt_q, collision_cnt_d;

  always_comb begin
    collision_d     = collision_q | drop_a;
    collision_cnt_d = collision_cnt_q;
    if (drop_a && collision_cnt_q != 16'hFFFF)
      collision_cnt_d = collision_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q     <= 1'b0;
      collision_cnt_q <= 16'd0;
    end else begin
      collision_q     <= collision_d;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign bus.collision     = collision_q;
  assign bus.collision_cnt = collision_cnt_q;
`else
  assign bus.collision     = 1'b0;
  assign bus.collision_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_banked_scratchpad.sv
// Directed vector bench for banked_scratchpad at READ_LATENCY=3: table of single accesses
// plus a hand-written back-to-back read burst interrupted by reset.
module tb_banked_scratchpad;
  localparam int LAT = 3;
`ifdef SPAD_COLLISION_CNT_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef struct {
    string        name;
    logic         en_a;
    logic         we_a;
    logic [12:0]  addr_a;
    logic [31:0]  din_a;
    logic         en_b;
    logic [7:0]   we_b;
    logic [12:0]  addr_b;
    logic [255:0] din_b;
    logic         exp_va;
    logic [31:0]  exp_a;
    logic         exp_vb;
    logic [255:0] exp_b;
    logic         after_coll;
  } vec_t;

  logic clk;
  logic rst;
  int   n_applied;
  int   n_miscompares;
  logic [31:0]  last_a;
  logic [255:0] last_b;

  banked_scratchpad_if bus ();

  banked_scratchpad #(
    .ADDR_WIDTH(13), .DATA_WIDTH(32), .NUM_BANKS(8), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] setl(logic [255:0] r, int k, logic [31:0] v);
    r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic vec_t mk(string n, logic ea, logic wa, logic [12:0] aa, logic [31:0] da,
                              logic eb, logic [7:0] wb, logic [12:0] ab, logic [255:0] db,
                              logic va, logic [31:0] xa, logic vb, logic [255:0] xb, logic ac);
    vec_t v;
    v.name = n; v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.exp_va = va; v.exp_a = xa; v.exp_vb = vb; v.exp_b = xb; v.after_coll = ac;
    return v;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    bus.en_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.din_a = '0;
    bus.en_b = 1'b0; bus.we_b = '0;   bus.addr_b = '0; bus.din_b = '0;
  endtask

  // One access cycle, then idle until the result is due at the pipeline output
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    bus.en_a = v.en_a; bus.we_a = v.we_a; bus.addr_a = v.addr_a; bus.din_a = v.din_a;
    bus.en_b = v.en_b; bus.we_b = v.we_b; bus.addr_b = v.addr_b; bus.din_b = v.din_b;
    @(negedge clk);
    driveIdle();
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic checkOutput(vec_t v);
    if (v.exp_va) last_a = v.exp_a;
    if (v.exp_vb) last_b = v.exp_b;
    check({v.name, ".va"}, {255'b0, bus.dout_a_valid}, {255'b0, v.exp_va});
    check({v.name, ".dout_a"}, {224'b0, bus.dout_a}, {224'b0, last_a});
    check({v.name, ".vb"}, {255'b0, bus.dout_b_valid}, {255'b0, v.exp_vb});
    check({v.name, ".dout_b"}, bus.dout_b, last_b);
    check({v.name, ".coll"}, {255'b0, bus.collision}, {255'b0, COLL_EN & v.after_coll});
    check({v.name, ".cnt"}, {240'b0, bus.collision_cnt}, {255'b0, COLL_EN & v.after_coll});
    @(negedge clk);
    check({v.name, ".pulse"}, {254'b0, bus.dout_a_valid, bus.dout_b_valid}, 256'b0);
  endtask

  vec_t         tbl [15];
  logic [255:0] r0, r8, r9, zr;

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    last_a        = '0;
    last_b        = '0;
    zr            = '0;
    driveIdle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.dout_a", {224'b0, bus.dout_a}, 256'b0);
    check("reset.dout_b", bus.dout_b, 256'b0);
    check("reset.valids", {254'b0, bus.dout_a_valid, bus.dout_b_valid}, 256'b0);
    check("reset.coll", {239'b0, bus.collision, bus.collision_cnt}, 256'b0);
    rst = 1'b0;

    r0 = '0;
    for (int k = 0; k < 8; k++) r0 = setl(r0, k, 32'h100 + k);
    r8 = setl(setl(r0, 3, 32'h3333), 4, 32'h4444);
    r9 = setl(r8, 0, 32'hBEEF);

    tbl[0]  = mk("b_write_row",   0, 0, 13'h000, 0,            1, 8'hFF, 13'h028, r0,                     0, 0,            0, 0,                       0);
    tbl[1]  = mk("b_read_row",    0, 0, 13'h000, 0,            1, 8'h00, 13'h028, 0,                      0, 0,            1, r0,                      0);
    tbl[2]  = mk("a_write",       1, 1, 13'h02B, 32'hDEAD,     0, 8'h00, 13'h000, 0,                      0, 0,            0, 0,                       0);
    tbl[3]  = mk("b_read_a_wr",   0, 0, 13'h000, 0,            1, 8'h00, 13'h028, 0,                      0, 0,            1, setl(r0, 3, 32'hDEAD),   0);
    tbl[4]  = mk("a_read",        1, 0, 13'h02B, 0,            0, 8'h00, 13'h000, 0,                      1, 32'hDEAD,     0, 0,                       0);
    tbl[5]  = mk("collision",     1, 1, 13'h02B, 32'h1111,     1, 8'h08, 13'h028, setl(zr, 3, 32'h2222),  0, 0,            0, 0,                       1);
    tbl[6]  = mk("a_read_b_won",  1, 0, 13'h02B, 0,            0, 8'h00, 13'h000, 0,                      1, 32'h2222,     0, 0,                       1);
    tbl[7]  = mk("diff_bank_wr",  1, 1, 13'h02B, 32'h3333,     1, 8'h10, 13'h028, setl(zr, 4, 32'h4444),  0, 0,            0, 0,                       1);
    tbl[8]  = mk("b_read_both",   0, 0, 13'h000, 0,            1, 8'h00, 13'h028, 0,                      0, 0,            1, r8,                      1);
    tbl[9]  = mk("read_first",    1, 0, 13'h028, 0,            1, 8'h01, 13'h028, setl(zr, 0, 32'hBEEF),  1, 32'h100,      0, 0,                       1);
    tbl[10] = mk("a_read_new",    1, 0, 13'h028, 0,            0, 8'h00, 13'h000, 0,                      1, 32'hBEEF,     0, 0,                       1);
    tbl[11] = mk("dual_read",     1, 0, 13'h02F, 0,            1, 8'h00, 13'h02D, 0,                      1, 32'h107,      1, r9,                      1);
    tbl[12] = mk("a_write_row6",  1, 1, 13'h030, 32'hCAFE,     0, 8'h00, 13'h000, 0,                      0, 0,            0, 0,                       1);
    tbl[13] = mk("a_read_row6",   1, 0, 13'h030, 0,            0, 8'h00, 13'h000, 0,                      1, 32'hCAFE,     0, 0,                       1);
    tbl[14] = mk("a_read_row5b0", 1, 0, 13'h028, 0,            0, 8'h00, 13'h000, 0,                      1, 32'hBEEF,     0, 0,                       1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Back-to-back row reads, then reset while the pipeline is full; writes during reset are ignored
    for (int cyc = 0; cyc < 16; cyc++) begin
      driveIdle();
      rst = 1'b0;
      if (cyc < 8) begin
        bus.en_b = 1'b1; bus.addr_b = 13'h028;
      end else if (cyc < 10) begin
        rst = 1'b1;
        bus.en_b = 1'b1; bus.addr_b = 13'h028;
        bus.en_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 13'h028; bus.din_a = 32'h9999;
      end
      @(negedge clk);
      check($sformatf("burst.vb%0d", cyc), {255'b0, bus.dout_b_valid}, {255'b0, (cyc >= 2 && cyc <= 7)});
      if (cyc >= 2 && cyc <= 7) check($sformatf("burst.db%0d", cyc), bus.dout_b, r9);
    end
    driveIdle();
    rst = 1'b0;
    check("post_rst.dout_b", bus.dout_b, 256'b0);
    check("post_rst.va", {255'b0, bus.dout_a_valid}, 256'b0);
    last_a = '0;
    last_b = '0;
    tbl[14].after_coll = 1'b0;
    applyStimulus(tbl[14]);
    checkOutput(tbl[14]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end
endmodule
